router_fsm: RTL

- Controller FSM for the 1x3 packet router.
- Sequences each incoming packet through header decode, first-byte load, payload load, parity load and parity check.
- Drives write_enb_reg and detect_add into the synchronizer, and the load/state strobes into the register block.
- Stalls the source (busy) while the target FIFO is full or still draining, and aborts on the destination's soft reset.

---
 rtl/router_fsm_if.sv | 60 ++++++
 rtl/router_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/router_fsm_if.sv
// router_fsm_if
//   Bundles the handshake and status signals that run between the packet
//   source, the synchronizer, the register block and the router controller.
//   Clock and reset are not part of the bundle; they are plain ports on the
//   controller.
//
//   slave  : the router_fsm side (status inputs, strobe outputs)
//   master : the environment side (drives the status, observes the strobes)
//
//   Status (master -> slave):
//     pkt_valid            source is presenting packet bytes
//     data_in[1:0]         header address field (3 is invalid)
//     fifo_full            full flag of the currently addressed FIFO
//     fifo_empty_0..2      per-port FIFO empty flags
//     soft_reset_0..2      per-port read-timeout soft resets
//     parity_done          register block has written the parity byte
//     low_pkt_valid        pkt_valid dropped while the FIFO was full
//   Strobes (slave -> master):
//     detect_add, lfd_state, ld_state, laf_state, full_state,
//     write_enb_reg, rst_int_reg, busy
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm
//   Controller for the 1x3 packet router. Walks each packet through header
//   decode, first-byte load, payload load, parity load and parity check,
//   stalling the source while the target FIFO is full or still draining and
//   abandoning the packet on the addressed port's soft reset.
//
//   Ports:
//     clock   rising-edge clock
//     resetn  synchronous, active-low reset
//     bus     router_fsm_if.slave (status in, state strobes out)
//
//   state              | meaning
//   -------------------+-------------------------------------------------
//   DECODE_ADDRESS     | idle; waiting for a header with a valid address
//   WAIT_TILL_EMPTY    | target FIFO still holds the previous packet
//   LOAD_FIRST_DATA    | header byte written to the FIFO
//   LOAD_DATA          | payload bytes being written
//   FIFO_FULL_STATE    | target FIFO full; source held
//   LOAD_AFTER_FULL    | FIFO drained; write the held byte and decide
//   LOAD_PARITY        | parity byte written
//   CHECK_PARITY_ERROR | parity compared; internal parity regs cleared
module router_fsm (
    input  logic              clock,
    input  logic              resetn,
    router_fsm_if.slave       bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [1:0] addr;

    logic       hdr_ok;
    logic       empty_hdr;
    logic       empty_addr;
    logic       soft_rst_addr;

    assign hdr_ok = bus.pkt_valid && (bus.data_in != 2'd3);

    // Header decode looks at the live address; later states use the
    // captured one, since data_in carries payload by then.
    always_comb begin
        empty_hdr     = 1'b0;
        empty_addr    = 1'b0;
        soft_rst_addr = 1'b0;
        case (bus.data_in)
            2'd0:    empty_hdr = bus.fifo_empty_0;
            2'd1:    empty_hdr = bus.fifo_empty_1;
            2'd2:    empty_hdr = bus.fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
        case (addr)
            2'd0: begin
                empty_addr    = bus.fifo_empty_0;
                soft_rst_addr = bus.soft_reset_0;
            end
            2'd1: begin
                empty_addr    = bus.fifo_empty_1;
                soft_rst_addr = bus.soft_reset_1;
            end
            2'd2: begin
                empty_addr    = bus.fifo_empty_2;
                soft_rst_addr = bus.soft_reset_2;
            end
            default: begin
                empty_addr    = 1'b0;
                soft_rst_addr = 1'b0;
            end
        endcase
    end

    always_comb begin
        nxt = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok)
                    nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else
                    nxt = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY:
                nxt = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)
                    nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    nxt = LOAD_PARITY;
                else
                    nxt = LOAD_DATA;
            end
            FIFO_FULL_STATE:
                nxt = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    nxt = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    nxt = LOAD_PARITY;
                else
                    nxt = LOAD_DATA;
            end
            LOAD_PARITY:
                nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
                nxt = DECODE_ADDRESS;
        endcase
        // The addressed port's timeout abandons the packet from any state.
        if ((state != DECODE_ADDRESS) && soft_rst_addr)
            nxt = DECODE_ADDRESS;
    end

    // Strobes are registered from the next state so they line up with the
    // state register and never see the inputs combinationally.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state             <= DECODE_ADDRESS;
            addr              <= 2'd0;
            bus.detect_add    <= 1'b1;
            bus.lfd_state     <= 1'b0;
            bus.ld_state      <= 1'b0;
            bus.laf_state     <= 1'b0;
            bus.full_state    <= 1'b0;
            bus.write_enb_reg <= 1'b0;
            bus.rst_int_reg   <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state <= nxt;
            if ((state == DECODE_ADDRESS) && hdr_ok)
                addr <= bus.data_in;
            bus.detect_add    <= (nxt == DECODE_ADDRESS);
            bus.lfd_state     <= (nxt == LOAD_FIRST_DATA);
            bus.ld_state      <= (nxt == LOAD_DATA);
            bus.laf_state     <= (nxt == LOAD_AFTER_FULL);
            bus.full_state    <= (nxt == FIFO_FULL_STATE);
            bus.write_enb_reg <= (nxt == LOAD_DATA) || (nxt == LOAD_PARITY)
                                 || (nxt == LOAD_AFTER_FULL);
            bus.rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
            bus.busy          <= (nxt != DECODE_ADDRESS) && (nxt != LOAD_DATA);
        end
    end

endmodule
